mem_arbiter: RTL and testbench

- Shares one single-port synchronous memory (1-cycle read latency) between the processor's instruction-fetch port and its data port.
- Sits between the pipelined processor (INST/INST_ADDR, DATA_* ports) and a unified instruction/data memory.
- Grants one access at a time, returns read data with a per-port ACK, and exposes busy status so the pipeline can stall.

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one single-port synchronous memory
// Optional fetch anti-starvation counter: define MEM_ARB_FAIRNESS_EN.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state;
  logic   owner_d;
  logic   owner_we;
  logic   grant_d;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] loss_cnt;

  // Once fetch has lost MAX_WAIT ties in a row, the next tie goes to fetch.
  assign grant_d = d_req && !(if_req && (loss_cnt == CNT_W'(MAX_WAIT)));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      loss_cnt <= '0;
    end else if (state == IDLE && if_req) begin
      if (!grant_d)
        loss_cnt <= '0;
      else if (loss_cnt != CNT_W'(MAX_WAIT))
        loss_cnt <= loss_cnt + CNT_W'(1);
    end
  end
`else
  // Data drains the older pipeline instruction, so it always wins a tie.
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      owner_we  <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state   <= ISSUE;
            busy    <= 1'b1;
            owner_d <= grant_d;
            if (grant_d) begin
              mem_addr <= d_addr;
              mem_we   <= d_we;
              owner_we <= d_we;
              if (d_we)
                mem_wdata <= d_wdata;
            end else begin
              mem_addr <= if_addr;
              owner_we <= 1'b0;
            end
          end
        end
        ISSUE: begin
          state <= RESP;
          if (owner_d) begin
            d_ack <= 1'b1;
            if (!owner_we)
              d_rdata <= mem_rdata;
          end else begin
            if_ack   <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        RESP: begin
          // The mandatory IDLE cycle keeps a REQ held past its ACK from being re-granted.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a word-level memory model
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .nrst(nrst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory seen by the DUT (256 words) and the bench's expected contents.
  logic [31:0] mem_arr [256];
  logic [31:0] ref_mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] last_if = '0;
  logic [31:0] last_d = '0;

  assign mem_rdata = mem_arr[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we)
      mem_arr[mem_addr[9:2]] <= mem_wdata;
    else if (pl_en)
      mem_arr[pl_idx] <= pl_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [7:0] w;
    w = 8'($urandom_range(0, 255));
    return {22'h0, w, 2'b00};
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_if_ack"}, if_ack, 1'b0);
    chk({tag, "_d_ack"}, d_ack, 1'b0);
    chk({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
  endtask

  // One access from an idle arbiter; ACK expected in the second cycle, BUSY for two.
  task automatic run_access(input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input string tag);
    int  busy_cnt = 0;
    int  we_cnt = 0;
    bit  got = 0;
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      if_addr = $urandom;
    end else begin
      if_req = 1'b1; if_addr = addr;
      d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
    end
    for (int lat = 1; lat <= 5; lat++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (mem_we) we_cnt++;
      if (lat == 1) begin
        chk({tag, "_mem_addr"}, mem_addr, addr);
        chk({tag, "_mem_we"}, mem_we, is_d && we);
        if (is_d && we) chk({tag, "_mem_wdata"}, mem_wdata, wdata);
      end
      if ((is_d ? d_ack : if_ack) && !got) begin
        got = 1;
        chk({tag, "_ack_lat"}, lat, 2);
        chk({tag, "_other_ack"}, is_d ? if_ack : d_ack, 1'b0);
        if (is_d && we) begin
          ref_mem[addr[9:2]] = wdata;
          chk({tag, "_d_rdata_hold"}, d_rdata, last_d);
        end else if (is_d) begin
          chk({tag, "_d_rdata"}, d_rdata, ref_mem[addr[9:2]]);
          last_d = ref_mem[addr[9:2]];
        end else begin
          chk({tag, "_if_rdata"}, if_rdata, ref_mem[addr[9:2]]);
          last_if = ref_mem[addr[9:2]];
        end
        chk({tag, "_if_rdata_hold"}, if_rdata, last_if);
        if (is_d) d_req = 1'b0; else if_req = 1'b0;
      end
    end
    chk({tag, "_acked"}, got, 1'b1);
    chk({tag, "_busy_cycles"}, busy_cnt, 2);
    chk({tag, "_we_pulses"}, we_cnt, (is_d && we) ? 1 : 0);
  endtask

  // D_REQ held 'hold' cycles past its ACK; a second grant may only start at E3.
  task automatic stale_guard(input int hold, input string tag);
    int acks = 0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h48;
    for (int lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (d_ack) begin
        acks++;
        chk({tag, "_rdata"}, d_rdata, ref_mem[8'h12]);
        last_d = ref_mem[8'h12];
      end
      if (lat == 3) chk({tag, "_idle_gap"}, busy, 1'b0);
      if (lat == 4) chk({tag, "_regrant_e3"}, busy, hold >= 2);
      if (lat == 2 + hold) d_req = 1'b0;
    end
    chk({tag, "_ack_count"}, acks, (hold >= 2) ? 2 : 1);
  endtask

  initial begin
    int  lat_d, lat_i;
    int  dcount, acks_before;
    bit  if_seen;
    logic [31:0] a_d, a_i, v44;

    #1;
    chk_idle_outputs("reset");

    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[8'h04] = 32'h2008_0005;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 8'(i); pl_data = ref_mem[i];
    end
    @(negedge clk);
    pl_en = 1'b0;
    nrst = 1'b1;

    run_access(1'b0, 1'b0, 32'h10, 32'h0, "fetch_read");
    chk("fetch_word", if_rdata, 32'h2008_0005);
    run_access(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, "d_write");
    run_access(1'b1, 1'b0, 32'h40, 32'h0, "d_read");
    chk("d_readback", d_rdata, 32'hDEAD_BEEF);

    for (int n = 0; n < 24; n++)
      run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom, "rand");

    // Simultaneous requests: data first, fetch three cycles later.
    a_d = rand_addr(); a_i = rand_addr();
    lat_d = -1; lat_i = -1;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = a_d;
    if_req = 1'b1; if_addr = a_i;
    for (int lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (d_ack && if_ack) chk("both_ack_same_cycle", 1'b1, 1'b0);
      if (d_ack) begin
        lat_d = lat; d_req = 1'b0;
        chk("simul_d_rdata", d_rdata, ref_mem[a_d[9:2]]);
        last_d = ref_mem[a_d[9:2]];
      end
      if (if_ack) begin
        lat_i = lat; if_req = 1'b0;
        chk("simul_if_rdata", if_rdata, ref_mem[a_i[9:2]]);
        last_if = ref_mem[a_i[9:2]];
      end
    end
    chk("simul_d_lat", lat_d, 2);
    chk("simul_if_lat", lat_i, 5);

    stale_guard(1, "stale1");
    stale_guard(2, "stale2");

    // Reset during ISSUE of a write to 0x44.
    v44 = ref_mem[8'h11];
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = ~v44;
    @(negedge clk);
    chk("rst_write_issue_we", mem_we, 1'b1);
    #2;
    nrst = 1'b0;
    #1;
    chk_idle_outputs("rst_async");
    d_req = 1'b0; d_we = 1'b0;
    last_d = '0; last_if = '0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    chk("rst_mem44_unchanged", mem_arr[8'h11], v44);
    dcount = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (d_ack) dcount++;
    end
    chk("rst_no_d_ack", dcount, 0);
    chk_idle_outputs("rst_release");

    // Continuous data traffic with a pending fetch.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = rand_addr();
    if_req = 1'b1; if_addr = 32'h20;
    dcount = 0; if_seen = 0; acks_before = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (d_ack) begin
        chk("starve_d_rdata", d_rdata, ref_mem[d_addr[9:2]]);
        dcount++;
        d_addr = rand_addr();
      end
      if (if_ack && !if_seen) begin
        if_seen = 1; acks_before = dcount; if_req = 1'b0;
        chk("starve_if_rdata", if_rdata, ref_mem[8'h08]);
      end
    end
`ifdef MEM_ARB_FAIRNESS_EN
    chk("fair_if_acked", if_seen, 1'b1);
    chk("fair_grants_before_fetch", acks_before, 4);
`else
    chk("starve_if_never_acked", if_seen, 1'b0);
    chk("starve_d_grants", dcount, 10);
`endif
    d_req = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (if_ack && !if_seen) begin
        if_seen = 1; if_req = 1'b0;
        chk("drain_if_rdata", if_rdata, ref_mem[8'h08]);
      end
    end
    chk("drain_if_acked", if_seen, 1'b1);
    chk("drain_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
